// File: rtl/coherence_pkg.sv
// coherence_pkg: MSI line-state codes, bus message codes and snoop FSM encoding.
package coherence_pkg;
   localparam logic [1:0] ST_INVALID   = 2'b00;
   localparam logic [1:0] ST_SHARED    = 2'b01;
   localparam logic [1:0] ST_EXCLUSIVE = 2'b10;
   localparam logic [2:0] MSG_NONE    = 3'b000;
   localparam logic [2:0] MSG_RD_MISS = 3'b001;
   localparam logic [2:0] MSG_WR_MISS = 3'b010;
   localparam logic [2:0] MSG_INVAL   = 3'b011;
   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_UPDATE} snoop_state_e;
endpackage

// File: rtl/coherence_line_table.sv
// coherence_line_table: per-line MSI state and tag storage with one combinational read port.
module coherence_line_table
   import coherence_pkg::*;
#(
   parameter int NUM_LINES = 4,
   parameter int IDX_W     = 2,
   parameter int TAG_W     = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             snoop_we_i,
   input  logic [IDX_W-1:0] snoop_index_i,
   input  logic [1:0]       snoop_state_i,
   input  logic             local_we_i,
   input  logic [IDX_W-1:0] local_index_i,
   input  logic [TAG_W-1:0] local_tag_i,
   input  logic [1:0]       local_state_i,
   input  logic [IDX_W-1:0] rd_index_i,
   output logic [1:0]       rd_state_o,
   output logic [TAG_W-1:0] rd_tag_o
);
   logic [1:0]       state_q [NUM_LINES];
   logic [TAG_W-1:0] tag_q   [NUM_LINES];
   // The controller stalls same-index local writes while busy, so the two writers never collide.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= '{default: ST_INVALID};
         tag_q   <= '{default: '0};
      end else begin
         for (int i = 0; i < NUM_LINES; i++) begin
            if (snoop_we_i && snoop_index_i == IDX_W'(i)) begin
               state_q[i] <= snoop_state_i;
            end else if (local_we_i && local_index_i == IDX_W'(i)) begin
               state_q[i] <= local_state_i;
               tag_q[i]   <= local_tag_i;
            end
         end
      end
   end
   assign rd_state_o = state_q[rd_index_i];
   assign rd_tag_o   = tag_q[rd_index_i];
endmodule

// File: rtl/snoop_controller.sv
// snoop_controller: bus-side MSI snooper; applies remote-request transitions and
// drives the writeback/abort handshake when a remote request hits an exclusive line.
module snoop_controller
   import coherence_pkg::*;
#(
   parameter int NUM_LINES = 4,
   parameter int IDX_W     = 2,
   parameter int TAG_W     = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             bus_valid,
   input  logic [2:0]       bus_msg,
   input  logic [IDX_W-1:0] bus_index,
   input  logic [TAG_W-1:0] bus_tag,
   output logic             bus_ready,
   input  logic             local_we,
   input  logic [IDX_W-1:0] local_index,
   input  logic [TAG_W-1:0] local_tag,
   input  logic [1:0]       local_state,
   output logic             local_stall,
   output logic             writeback_block,
   output logic             abort_access,
   output logic [IDX_W-1:0] wb_index,
   input  logic             wb_ack,
   output logic             snoop_done,
   output logic             snoop_hit,
   output logic             protocol_error
);
   snoop_state_e     state_q, state_d;
   logic [2:0]       msg_q;
   logic [IDX_W-1:0] idx_q;
   logic [TAG_W-1:0] tag_q;
   logic             done_q, done_d, hit_q, hit_d, perr_q, perr_d;
   logic [1:0]       rd_state;
   logic [TAG_W-1:0] rd_tag;
   logic             idle, accept, hit, rd_excl;
   assign idle    = state_q == S_IDLE;
   assign accept  = idle && bus_valid && (bus_msg inside {MSG_RD_MISS, MSG_WR_MISS, MSG_INVAL});
   assign hit     = rd_tag == tag_q && rd_state != ST_INVALID;
   assign rd_excl = rd_state == ST_EXCLUSIVE;
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      hit_d   = 1'b0;
      perr_d  = 1'b0;
      case (state_q)
         S_IDLE:      state_d = accept ? S_LOOKUP : S_IDLE;
         S_LOOKUP: begin
            state_d = !hit ? S_IDLE : (rd_excl && msg_q != MSG_INVAL) ? S_WRITEBACK : S_UPDATE;
            done_d  = !hit;
         end
         S_WRITEBACK: state_d = wb_ack ? S_UPDATE : S_WRITEBACK;
         S_UPDATE: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            hit_d   = 1'b1;
            perr_d  = msg_q == MSG_INVAL && rd_excl;
         end
         default:     state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         msg_q   <= MSG_NONE;
         idx_q   <= '0;
         tag_q   <= '0;
         done_q  <= 1'b0;
         hit_q   <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         hit_q   <= hit_d;
         perr_q  <= perr_d;
         if (accept) begin
            msg_q <= bus_msg;
            idx_q <= bus_index;
            tag_q <= bus_tag;
         end
      end
   end
   assign bus_ready       = idle;
   assign local_stall     = !idle && local_we && local_index == idx_q;
   assign writeback_block = state_q == S_WRITEBACK;
   assign abort_access    = writeback_block;
   assign wb_index        = writeback_block ? idx_q : '0;
   assign snoop_done      = done_q;
   assign snoop_hit       = hit_q;
   assign protocol_error  = perr_q;
   // A hit line is shared or exclusive; only a remote read miss leaves it readable.
   coherence_line_table #(.NUM_LINES(NUM_LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_table (
      .clock         (clock),
      .reset         (reset),
      .snoop_we_i    (state_q == S_UPDATE),
      .snoop_index_i (idx_q),
      .snoop_state_i (msg_q == MSG_RD_MISS ? ST_SHARED : ST_INVALID),
      .local_we_i    (local_we && !local_stall),
      .local_index_i (local_index),
      .local_tag_i   (local_tag),
      .local_state_i (local_state),
      .rd_index_i    (idx_q),
      .rd_state_o    (rd_state),
      .rd_tag_o      (rd_tag)
   );
endmodule

// File: tb/tb_snoop_controller.sv
// tb_snoop_controller: randomized snoop/local-write traffic against a line-array model,
// with a scoreboard monitor checking every snoop completion.
module tb_snoop_controller;
   logic       clock = 1'b0;
   logic       reset;
   logic       bus_valid, bus_ready, local_we, local_stall;
   logic [2:0] bus_msg;
   logic [1:0] bus_index, local_index, local_state, wb_index;
   logic [7:0] bus_tag, local_tag;
   logic       writeback_block, abort_access, wb_ack;
   logic       snoop_done, snoop_hit, protocol_error;

   snoop_controller #(.NUM_LINES(4), .IDX_W(2), .TAG_W(8)) dut (
      .clock(clock), .reset(reset), .bus_valid(bus_valid), .bus_msg(bus_msg),
      .bus_index(bus_index), .bus_tag(bus_tag), .bus_ready(bus_ready),
      .local_we(local_we), .local_index(local_index), .local_tag(local_tag),
      .local_state(local_state), .local_stall(local_stall),
      .writeback_block(writeback_block), .abort_access(abort_access),
      .wb_index(wb_index), .wb_ack(wb_ack), .snoop_done(snoop_done),
      .snoop_hit(snoop_hit), .protocol_error(protocol_error)
   );

   always #5 clock = ~clock;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;
   typedef struct { bit hit; bit perr; int at; } exp_t;
   exp_t sbq[$];
   exp_t got;
   int m_state[4];
   int m_tag[4];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (snoop_done) begin
            if (sbq.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
               got = sbq.pop_front();
               chk("snoop_hit", snoop_hit, got.hit);
               chk("protocol_error", protocol_error, got.perr);
               chk("done_cycle", cyc, got.at);
            end
         end else if (protocol_error) begin
            n_chk++; n_fail++;
            $display("FAIL stray_perr: got perr=1 without done expected 0 (cycle %0d)", cyc);
         end
      end
   end

   task automatic local_write_idle(int i, int t, int s);
      @(negedge clock);
      local_we = 1; local_index = 2'(i); local_tag = 8'(t); local_state = 2'(s);
      #1 chk("idle_stall", local_stall, 0);
      @(posedge clock);
      #1 local_we = 0;
      m_state[i] = s; m_tag[i] = t;
   endtask

   // Issued in a busy cycle; consumes that cycle and returns on the next negedge.
   task automatic local_try(int i, int sidx);
      int t, s;
      t = $urandom_range(0, 3); s = $urandom_range(0, 2);
      local_we = 1; local_index = 2'(i); local_tag = 8'(t); local_state = 2'(s);
      #1 chk("busy_stall", local_stall, i == sidx);
      @(negedge clock);
      local_we = 0;
      if (i != sidx) begin m_state[i] = s; m_tag[i] = t; end
   endtask

   task automatic do_snoop(int msg, int idx, int tag, int wbd, int lw1, int lw2);
      bit hit, ex, wb;
      int c0, k;
      exp_t e;
      @(negedge clock);
      chk("bus_ready_idle", bus_ready, 1);
      bus_valid = 1; bus_msg = 3'(msg); bus_index = 2'(idx); bus_tag = 8'(tag);
      hit = m_state[idx] != 0 && m_tag[idx] == tag;
      ex  = m_state[idx] == 2;
      wb  = hit && ex && msg != 3;
      @(negedge clock);
      bus_valid = 0;
      c0 = cyc;
      chk("bus_ready_busy", bus_ready, 0);
      if (!wb) begin
         e.hit = hit; e.perr = hit && ex && msg == 3; e.at = hit ? c0 + 2 : c0 + 1;
         sbq.push_back(e);
      end
      if (hit) m_state[idx] = (msg == 1) ? 1 : 0;
      wb_ack = 1'($urandom_range(0, 1));
      if (lw1 >= 0) local_try(lw1, idx); else @(negedge clock);
      wb_ack = 0;
      chk("wb_block", writeback_block, wb);
      chk("abort", abort_access, wb);
      if (wb) begin
         chk("wb_index", wb_index, idx);
         if (lw2 >= 0) local_try(lw2, idx); else @(negedge clock);
         for (int j = 0; j < wbd; j++) begin
            chk("wb_held", writeback_block, 1);
            @(negedge clock);
         end
         wb_ack = 1;
         @(negedge clock);
         wb_ack = 0;
         e.hit = 1; e.perr = 0; e.at = cyc + 1;
         sbq.push_back(e);
         chk("wb_drop", writeback_block, 0);
         chk("abort_drop", abort_access, 0);
      end
      k = 0;
      while (!bus_ready && k < 20) begin @(negedge clock); k++; end
      chk("return_idle", bus_ready, 1);
   endtask

   task automatic reserved_msg();
      int r;
      r = $urandom_range(0, 4);
      @(negedge clock);
      bus_valid = 1; bus_msg = (r == 0) ? 3'd0 : 3'(3 + r); bus_index = 2'($urandom);
      bus_tag = 8'($urandom_range(0, 3));
      @(negedge clock);
      bus_valid = 0;
      chk("reserved_ignored", bus_ready, 1);
   endtask

   task automatic reset_in_wb(int idx);
      local_write_idle(idx, 'h66, 2);
      @(negedge clock);
      bus_valid = 1; bus_msg = 3'd1; bus_index = 2'(idx); bus_tag = 8'h66;
      @(negedge clock);
      bus_valid = 0;
      @(negedge clock);
      chk("pre_reset_wb", writeback_block, 1);
      reset = 1;
      #1;
      chk("rst_ready", bus_ready, 1);
      chk("rst_wb", writeback_block, 0);
      chk("rst_abort", abort_access, 0);
      for (int i = 0; i < 4; i++) begin m_state[i] = 0; m_tag[i] = 0; end
      @(negedge clock);
      reset = 0;
      repeat (4) @(negedge clock);
      chk("post_reset_idle", bus_ready, 1);
   endtask

   initial begin
      reset = 1; bus_valid = 0; bus_msg = 0; bus_index = 0; bus_tag = 0;
      local_we = 0; local_index = 0; local_tag = 0; local_state = 0; wb_ack = 0;
      for (int i = 0; i < 4; i++) begin m_state[i] = 0; m_tag[i] = 0; end
      repeat (2) @(negedge clock);
      chk("reset_ready", bus_ready, 1);
      chk("reset_wb", writeback_block, 0);
      chk("reset_abort", abort_access, 0);
      chk("reset_wbidx", wb_index, 0);
      chk("reset_done", snoop_done, 0);
      chk("reset_perr", protocol_error, 0);
      reset = 0;
      local_write_idle(2, 'h5A, 1);
      do_snoop(1, 2, 'h5A, 0, -1, -1);
      do_snoop(2, 2, 'h5A, 0, -1, -1);
      local_write_idle(1, 'h33, 2);
      do_snoop(2, 1, 'h33, 3, -1, -1);
      do_snoop(1, 1, 'h33, 0, -1, -1);
      local_write_idle(0, 'h11, 2);
      do_snoop(1, 0, 'h12, 0, -1, -1);
      do_snoop(1, 0, 'h11, 1, -1, -1);
      local_write_idle(3, 'h44, 2);
      do_snoop(2, 3, 'h44, 2, 3, 0);
      local_write_idle(1, 'h77, 2);
      do_snoop(3, 1, 'h77, 0, -1, -1);
      do_snoop(1, 1, 'h77, 0, -1, -1);
      reset_in_wb(2);
      for (int i = 0; i < 4; i++) do_snoop(1, i, 0, 0, -1, -1);
      repeat (200) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 3) local_write_idle($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         else if (r == 3) reserved_msg();
         else do_snoop($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 4), $urandom_range(0, 4) - 1, $urandom_range(0, 4) - 1);
      end
      repeat (4) @(negedge clock);
      chk("queue_drained", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/snoop_controller.md
Name: snoop_controller

Overview:
Bus-side half of the MSI snooping protocol; consumes the bus messages (read miss / write miss / invalidate) that the CPU-side state machines of other caches drive onto the shared bus. Holds the per-line coherence state and tag for one cache and applies remote-request transitions. When a remote request hits an exclusive line, it drives a writeback/abort handshake toward memory. The CPU-side machine of the same cache writes its new line state into this table through a local update port.

Parameters:
NUM_LINES, 4, number of cache lines tracked (power of two, >=2)
IDX_W, 2, line index width = log2(NUM_LINES)
TAG_W, 8, address tag width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
bus_valid  in  1  remote bus message present this cycle
bus_msg  in  3  000 none, 001 read miss, 010 write miss, 011 invalidate, others reserved
bus_index  in  IDX_W  line index of remote request
bus_tag  in  TAG_W  tag of remote request
bus_ready  out  1  controller can accept a message (high only in IDLE)
local_we  in  1  CPU-side state write strobe
local_index  in  IDX_W  line written by CPU side
local_tag  in  TAG_W  tag written by CPU side
local_state  in  2  00 invalid, 01 shared, 10 exclusive
local_stall  out  1  local write refused this cycle (combinational)
writeback_block  out  1  exclusive line must be written back; held until wb_ack
abort_access  out  1  remote access must be aborted; same timing as writeback_block
wb_index  out  IDX_W  line being written back (valid while writeback_block)
wb_ack  in  1  memory has accepted the writeback
snoop_done  out  1  one-cycle pulse at end of each accepted snoop
snoop_hit  out  1  valid with snoop_done: tag matched a non-invalid line
protocol_error  out  1  one-cycle pulse: invalidate hit an exclusive line

Behaviour:
- Reset (async): all line states 00, tags 0, FSM IDLE, every output 0 except bus_ready = 1. Reset during WRITEBACK drops the transaction; no completion pulse is issued.
- States: IDLE, LOOKUP, WRITEBACK, UPDATE.
- IDLE: bus_ready = 1. When bus_valid is high and bus_msg is 001, 010 or 011, capture msg/index/tag and go to LOOKUP. Messages 000 and 1xx are ignored and the FSM stays in IDLE.
- LOOKUP (1 cycle): hit = (tag[idx] == captured tag) && state[idx] != 00.
  - Miss: pulse snoop_done with snoop_hit = 0, then go to IDLE.
  - Hit on exclusive with 001 or 010: go to WRITEBACK.
  - Otherwise: go to UPDATE.
- WRITEBACK: writeback_block = abort_access = 1, wb_index = captured index. Hold for as long as needed until wb_ack is sampled high, then go to UPDATE. Outputs drop on the cycle UPDATE is entered.
- UPDATE (1 cycle): write the next state, pulse snoop_done with snoop_hit = 1, then go to IDLE. Next-state rules:
  - shared + 001 -> shared
  - shared + 010 -> invalid
  - shared + 011 -> invalid
  - exclusive + 001 -> shared
  - exclusive + 010 -> invalid
  - exclusive + 011 -> invalid, with protocol_error pulsed in the same cycle
- Latency: a miss completes 2 cycles after acceptance. A hit with no writeback completes 3 cycles after acceptance. A writeback hit completes 1 cycle after wb_ack.
- Local port: in IDLE, a local_we writes the state and tag on the next edge. In any other state, local_stall = local_we && (local_index == captured index), and a stalled write is dropped. The CPU side retries.
- A local write to a different index proceeds in any state.
- bus_valid outside IDLE is ignored; the bus master must hold its message until bus_ready is high.
- wb_ack outside WRITEBACK is ignored.

Decomposition:
- Shared package coherence_pkg holds:
  - state constants ST_INVALID = 00, ST_SHARED = 01, ST_EXCLUSIVE = 10
  - bus message constants MSG_NONE, MSG_RD_MISS, MSG_WR_MISS, MSG_INVAL
  - the snoop FSM state encoding
- One sub-module, coherence_line_table: the NUM_LINES state/tag array with one write port (snoop update muxed with local write) and one combinational read port.

Test Plan:
1. Line 2 is shared with tag 0x5A; remote 001 index 2 tag 0x5A -> snoop_done with hit = 1 three cycles after acceptance; line 2 stays 01; writeback_block never asserts.
2. Line 1 is exclusive with tag 0x33; remote 010 -> writeback_block = abort_access = 1 and wb_index = 1 from cycle 2. wb_ack arrives 4 cycles later -> outputs drop, line 1 becomes 00, snoop_done pulses.
3. Line 0 is exclusive; remote 001 with tag mismatch -> snoop_hit = 0, state stays 10, no writeback.
4. Snoop in WRITEBACK on index 3; local_we to index 3 -> local_stall = 1 and the table is unchanged. local_we to index 0 in the same period -> written.
5. Line 1 is exclusive; remote 011 -> protocol_error pulses and line 1 becomes 00 with no writeback. Reset asserted during a WRITEBACK -> all states 00, bus_ready = 1, no snoop_done.
